// File: rtl/riscv_div_wbq.sv
// Two-entry writeback queue between the divide unit and the writeback port.
// Define RISCV_DIV_WBQ_BYPASS_EN to let a result reach writeback in its push cycle when the queue is empty.
module riscv_div_wbq #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_bubble,
    input  logic [XLEN-1:0] div_r,
    input  logic [4:0]      div_rd,
    output logic            wbq_stall,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_r,
    output logic [4:0]      wb_rd,
    output logic            wb_we,
    output logic            wbq_ovf
);

    logic [XLEN-1:0] mem_r  [DEPTH];
    logic [4:0]      mem_rd [DEPTH];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    logic push;
    logic full;
    logic fifo_valid;
    logic fifo_pop;
    logic bypass_take;
    logic store;
    logic overflow;

    // A flush discards a same-cycle push, so it is folded into push itself.
    always_comb begin
        push        = !div_bubble && !flush;
        full        = (count == 2'(DEPTH));
        fifo_valid  = (count != 2'd0);
        bypass_take = 1'b0;
`ifdef RISCV_DIV_WBQ_BYPASS_EN
        wb_valid    = fifo_valid || (push && !rst);
        wb_r        = fifo_valid ? mem_r[rd_ptr]  : div_r;
        wb_rd       = fifo_valid ? mem_rd[rd_ptr] : div_rd;
        bypass_take = !fifo_valid && push && wb_ready && !rst;
`else
        wb_valid    = fifo_valid;
        wb_r        = mem_r[rd_ptr];
        wb_rd       = mem_rd[rd_ptr];
`endif
        fifo_pop    = fifo_valid && wb_ready;
        store       = push && !bypass_take && (!full || fifo_pop);
        overflow    = push && full && !fifo_pop;
        wb_we       = wb_valid && (wb_rd != 5'd0);
        wbq_stall   = full || ((count == 2'd1) && wb_valid && !wb_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            wbq_ovf <= 1'b0;
        end else begin
            if (overflow)
                wbq_ovf <= 1'b1;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (store)
                    wr_ptr <= wr_ptr + 1'b1;
                if (fifo_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + {1'b0, store} - {1'b0, fifo_pop};
            end
        end
    end

    // Entry storage carries no reset; wb_valid qualifies it.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_r[wr_ptr]  <= div_r;
            mem_rd[wr_ptr] <= div_rd;
        end
    end

endmodule

// File: doc/riscv_div_wbq.md
RISCV_DIV_WBQ -- requirements
Module: riscv_div_wbq

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of the result datapath.
REQ-002 SHALL have parameter DEPTH, fixed at 2: number of result entries held.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port `clk`, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port `rst`, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port `flush`, input, 1 bit: discard all held results (pipeline redirect).
REQ-007 SHALL have port `div_bubble`, input, 1 bit: low means the divide unit presents a valid result this cycle.
REQ-008 SHALL have port `div_r`, input, XLEN bits: divide/remainder result.
REQ-009 SHALL have port `div_rd`, input, 5 bits: destination register of that result.
REQ-010 SHALL have port `wbq_stall`, output, 1 bit: high when the queue cannot accept another result; fed into `ex_stall`.
REQ-011 SHALL have port `wb_valid`, output, 1 bit: the head entry is presented to writeback.
REQ-012 SHALL have port `wb_ready`, input, 1 bit: writeback consumes the head this cycle.
REQ-013 SHALL have port `wb_r`, output, XLEN bits: head result.
REQ-014 SHALL have port `wb_rd`, output, 5 bits: head destination register.
REQ-015 SHALL have port `wb_we`, output, 1 bit: equals `wb_valid` and (`wb_rd` != 0).
REQ-016 SHALL have port `wbq_ovf`, output, 1 bit: sticky overflow flag.

Function
REQ-017 SHALL define push as `div_bubble`=0, and pop as `wb_valid`=1 and `wb_ready`=1.
REQ-018 SHALL be a FIFO with 2 entries, a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2); the pointers wrap modulo 2.
REQ-019 SHALL write {div_r, div_rd} at the write pointer on push, then advance the pointer; a result with rd=0 is still queued.
REQ-020 SHALL drive `wb_valid`=(count!=0), with `wb_r`/`wb_rd` taken from the read-pointer entry; a pop advances the read pointer.
REQ-021 SHALL deliver a pushed result on `wb_valid` in the cycle after the push (1-cycle latency) when the bypass is compiled out.
REQ-022 SHALL keep the head stable (`wb_r`, `wb_rd`, `wb_valid`) while `wb_valid`=1 and `wb_ready`=0.
REQ-023 SHALL on simultaneous push and pop leave count unchanged and move both pointers, including when count=2.
REQ-024 SHALL drive `wbq_stall` combinationally as (count=2) or (count=1 and `wb_valid`=1 and `wb_ready`=0).
REQ-025 SHALL on push with count=2 and no pop drop the result, leave the entries unchanged and set `wbq_ovf`.
REQ-026 SHALL clear `wbq_ovf` only by reset.
REQ-027 SHALL give `flush` priority over push and pop: count and both pointers return to 0 next cycle, and a same-cycle push is discarded.
REQ-028 SHALL treat `wb_ready` as don't-care while `wb_valid`=0.

Reset
REQ-029 SHALL on `rst` high immediately set count=0, pointers=0, `wb_valid`=0, `wb_we`=0, `wbq_stall`=0 and `wbq_ovf`=0.
REQ-030 SHALL make entry storage non-reset; `wb_r`/`wb_rd` are don't-care while `wb_valid`=0.
REQ-031 SHALL on reset asserted mid-operation lose all queued results, with no writeback strobe in or after the reset cycle.

Configuration
REQ-032 SHALL use macro RISCV_DIV_WBQ_BYPASS_EN to compile the bypass in or out.
REQ-033 SHALL when the macro is defined and a push occurs with count=0, present `div_r`/`div_rd` combinationally with `wb_valid`=1 in the same cycle.
REQ-034 SHALL under bypass, if `wb_ready`=1 that cycle, not store the entry and leave count=0; otherwise the entry is stored as normal.
REQ-035 SHALL when the macro is undefined never have a combinational path from `div_*` to `wb_*`, giving a fixed latency of 1 cycle.

Verification
REQ-036 SHALL cover single result: push div_r=0x7, rd=5 with wb_ready=1 -> next cycle wb_valid=1, wb_r=0x7, wb_we=1; then empty (bypass off: next cycle; bypass on: same cycle).
REQ-037 SHALL cover backpressure: wb_ready=0, push 0x11/rd3 then 0x22/rd4 -> count=2, wbq_stall=1; then wb_ready=1 -> 0x11 then 0x22 in order.
REQ-038 SHALL cover overflow: count=2, wb_ready=0, push 0x33 -> entries unchanged, wbq_ovf=1 sticky until rst.
REQ-039 SHALL cover full with simultaneous push/pop: count=2, wb_ready=1, push 0x44 -> 0x11 popped, count stays 2, 0x44 emerges after 0x22.
REQ-040 SHALL cover rd=0: push 0x55 with rd=0 -> wb_valid=1, wb_we=0.
REQ-041 SHALL cover flush and reset: count=2 with flush=1 and a same-cycle push -> count=0 next cycle, no wb_valid; rst asserted mid-stream -> wb_valid=0 immediately.
